// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Latency: write at edge N is popped at N+1 when idle; tx falls after N+1.
// Backpressure: none on the line; writes while full are dropped, producers watch full/level.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        wr_en,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Serialiser state
  state_t        state, state_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic          tx_nxt;
  logic          baud_last;

  // full is judged on the pre-pop level, so a write while full is lost even if a pop happens
  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign push      = wr_en && !full;
  assign busy      = (state != IDLE);
  assign baud_last = (baud_cnt == BAUD_LAST);

  // Byte storage: written on accepted push, no reset needed since level gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally; level tracks occupancy excluding the byte on the wire
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (!push && pop) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

  // Serialiser registers, including the registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_nxt;
      baud_cnt <= baud_nxt;
      tx       <= tx_nxt;
    end
  end

  // Next-state logic; the baud counter restarts on every state entry
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_nxt   = bit_cnt;
    baud_nxt  = baud_cnt + BW'(1);
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_nxt = '0;
          // Chain straight into the next start bit when more data is queued
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            bit_nxt   = '0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Line level for the upcoming state, so tx itself is always a flop output
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo with a frame-timing reference model and a UART receiver scoreboard.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       busy;
  logic       tx;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .busy    (busy),
    .tx      (tx)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of waiting bytes plus cycles left in the current frame
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] cur      = '0;
  int         ser_rem  = 0;
  int         rst_gen  = 0;
  int         acc_cnt  = 0;
  int         rx_cnt   = 0;
  bit         started  = 0;

  always @(posedge clk) begin : model
    bit emp;
    bit ful;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      ser_rem = 0;
      rst_gen++;
      started = 1;
    end else if (started) begin
      emp = (mq.size() == 0);
      ful = (mq.size() == DEPTH);
      if (ser_rem <= 1) begin
        if (!emp) begin
          cur     = mq.pop_front();
          ser_rem = FRAME;
        end else begin
          ser_rem = 0;
        end
      end else begin
        ser_rem--;
      end
      if (wr_en && !ful) begin
        mq.push_back(data_in);
        exp_q.push_back(data_in);
        acc_cnt++;
      end
    end
  end

  function automatic logic model_tx();
    int p;
    int b;
    if (ser_rem == 0) return 1'b1;
    p = FRAME - ser_rem;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    return 1'b1;
  endfunction

  // Cycle-accurate comparison of status outputs and line level
  always @(negedge clk) begin
    if (started) begin
      check("level", int'(level), mq.size());
      check("full",  int'(full),  int'(mq.size() == DEPTH));
      check("empty", int'(empty), int'(mq.size() == 0));
      check("busy",  int'(busy),  int'(ser_rem != 0));
      check("tx",    int'(tx),    int'(model_tx()));
    end
  end

  // UART receiver: decodes frames mid-bit and pops the expected byte
  initial begin : monitor
    logic [7:0] rx;
    logic       s0;
    logic       sp;
    int         g;
    wait (started);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        g = rst_gen;
        repeat (2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        sp = tx;
        if (g == rst_gen) begin
          check("start_bit", int'(s0), 0);
          check("stop_bit",  int'(sp), 1);
          check("frame_queued", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("frame_byte", int'(rx), int'(exp_q.pop_front()));
          rx_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((ser_rem != 0 || mq.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check("drain_in_time", int'(n < bound), 1);
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int rx0;
    int acc0;
    int sent;

    // Reset held with writes active: nothing may be queued or sent
    rst = 1'b1; wr_en = 1'b1; data_in = 8'h77;
    repeat (3) tick();
    rst = 1'b0; wr_en = 1'b0;
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_tx",    int'(tx),    1);
    check("rst_busy",  int'(busy),  0);
    repeat (20) tick();
    check("rst_no_frames", rx_cnt, 0);

    // Single byte and frame length
    wr_en = 1'b1; data_in = 8'hA5; tick(); wr_en = 1'b0;
    n = 0;
    repeat (60) begin
      tick();
      if (busy) n++;
    end
    check("single_frame_cycles", n, FRAME);
    check("single_rx_count", rx_cnt, 1);

    // Burst of five fills the FIFO; sixth write is dropped
    rx0 = rx_cnt;
    wr_en = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      data_in = 8'(b);
      tick();
    end
    check("burst_level", int'(level), 4);
    check("burst_full",  int'(full),  1);
    data_in = 8'h06; tick(); wr_en = 1'b0;
    check("burst_level_after_drop", int'(level), 4);
    wait_drain(400);
    check("burst_frames", rx_cnt - rx0, 5);

    // Push coinciding with the STOP->START pop keeps level unchanged
    wr_en = 1'b1;
    data_in = 8'h51; tick();
    data_in = 8'h52; tick();
    data_in = 8'h53; tick();
    wr_en = 1'b0;
    n = 0;
    while (ser_rem != 1 && n < 100) begin tick(); n++; end
    check("pushpop_found_stop_end", int'(n < 100), 1);
    check("pushpop_level_before", int'(level), 2);
    wr_en = 1'b1; data_in = 8'h3C; tick(); wr_en = 1'b0;
    check("pushpop_level_after", int'(level), 2);
    check("pushpop_busy", int'(busy), 1);
    wait_drain(400);

    // Reset during data bit 3 of 0xFF with two bytes queued
    rx0 = rx_cnt;
    wr_en = 1'b1;
    data_in = 8'hFF; tick();
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    wr_en = 1'b0;
    n = 0;
    while (ser_rem != FRAME - 17 && n < 100) begin tick(); n++; end
    check("midrst_reached_bit3", int'(n < 100), 1);
    check("midrst_level_before", int'(level), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_tx",    int'(tx),    1);
    check("midrst_level", int'(level), 0);
    check("midrst_busy",  int'(busy),  0);
    repeat (100) tick();
    check("midrst_no_frames", rx_cnt - rx0, 0);

    // Twelve bytes through a depth-4 FIFO, never letting it fill
    rx0 = rx_cnt;
    sent = 0;
    n = 0;
    while (sent < 12 && n < 3000) begin
      if (mq.size() < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        data_in = 8'h10 + 8'(sent);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      n++;
    end
    wr_en = 1'b0;
    check("wrap_all_written", sent, 12);
    wait_drain(1000);
    check("wrap_frames", rx_cnt - rx0, 12);

    // Random traffic including writes while full
    rx0 = rx_cnt;
    acc0 = acc_cnt;
    repeat (1500) begin
      wr_en = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    wait_drain(1000);
    check("random_frames", rx_cnt - rx0, acc_cnt - acc0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes on a single-cycle write strobe into an internal FIFO and serialises them as 8N1 frames, LSB first, on `tx`. It is the outbound side of the board's serial link, carrying results and echoes back to the host. It decouples producers, such as the network output stage or the loopback path, from the bit-rate timing. Producers may burst up to `FIFO_DEPTH` bytes without waiting on the line.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 16, byte capacity of the FIFO; must be a power of two, ≥ 2.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `data_in`  input  8  byte to enqueue.
- `wr_en`  input  1  enqueue strobe; accepted when `wr_en && !full`.
- `full`  output  1  FIFO holds `FIFO_DEPTH` bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `level`  output  $clog2(FIFO_DEPTH)+1  bytes currently in the FIFO. The byte being serialised is not counted.
- `busy`  output  1  serialiser is not IDLE.
- `tx`  output  1  serial line; idle high.

## Operation
- FIFO:
  - Circular buffer with write and read pointers of $clog2(FIFO_DEPTH) bits each; the pointers wrap naturally.
  - `level` is a separate counter.
  - A push occurs on `wr_en && !full`. `wr_en` while full is dropped silently: no state change.
  - A pop occurs only when the serialiser loads a byte.
  - Simultaneous push and pop leaves `level` unchanged. `full` is evaluated before the pop, so a write while full is dropped even if a pop happens in the same cycle.
  - `full = (level == FIFO_DEPTH)` and `empty = (level == 0)`, both combinational from `level`.
- Serialiser state machine: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If `!empty`, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx = shift[0]`. Each bit lasts `CLKS_PER_BIT` cycles, then the register shifts right. After bit index 7, go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles. At the end, if `!empty`, pop and go directly to START, so there is no idle gap between frames. Otherwise go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1, wraps at the bit boundary, and is reset on every state entry.
- `tx` is driven from a register and never combinational. `busy = (state != IDLE)`.

## Timing
- Reset values: `tx=1`, `busy=0`, `full=0`, `empty=1`, `level=0`. Pointers are 0 and the state is IDLE.
- Reset mid-frame aborts the frame. `tx` is high after the reset edge, and all FIFO contents are discarded.
- Write latency:
  - Write accepted at edge N: `level`/`empty` update after edge N.
  - If the serialiser was IDLE, the pop and entry to START happen at edge N+1, so `tx` falls after edge N+1.
  - On that same edge `level` returns to its pre-write value and `busy` rises.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles, from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the edge that ends STOP with the FIFO empty.
- A write arriving during STOP's last cycle is visible to the end-of-STOP check only from the following cycle onward. That byte is therefore sent after one IDLE cycle, not back-to-back.

## Test plan
Benches use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
- **Reset:** hold `rst` 3 cycles with `wr_en=1` → `tx=1`, `level=0`, `empty=1`, `busy=0`, and nothing is transmitted after release.
- **Single byte:** write 0xA5 at edge N →
  - `tx` falls after edge N+1.
  - Sampled mid-bit, the line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - The frame is 40 cycles, then `busy=0`.
- **Burst and full:** write 0x01..0x05 on 5 consecutive cycles →
  - 0x01 pops immediately.
  - 0x02..0x05 fill the FIFO, so `full=1` and `level=4`.
  - A sixth write of 0x06 while full is dropped.
  - Five contiguous frames with no idle gap (200 cycles) carry 0x01..0x05, and 0x06 never appears.
- **Simultaneous push/pop:** with the FIFO at level 2, write 0x3C on the STOP→START transition cycle → `level` stays 2 and the byte order is preserved.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF with 2 bytes queued → `tx=1` after the edge, `level=0`, and no further frames.
- **Pointer wrap:** stream 12 bytes 0x10..0x1B, keeping the FIFO non-full → all 12 bytes are received in order, with the pointers wrapping 3 times.
